// File: rtl/io_output.sv
// -----------------------------------------------------------------------------
// io_output
//   Memory-mapped output block. A store strobe with addr[7:2] selecting one of
//   five registers either loads an output port, pushes a word into a 4-deep
//   first-word-fall-through stream FIFO, or clears the sticky overflow flag.
//
// Ports
//   io_clk           clock, all state updates on the rising edge
//   resetn           asynchronous active-low reset
//   addr[31:0]       store address, only addr[7:2] is decoded
//   datain[31:0]     store data
//   write_io_enable  store strobe
//   out_port0..2     registered output ports
//   stream_data      FIFO head word (0 when empty)
//   stream_valid     FIFO non-empty
//   stream_ready     consumer accepts the head word this edge
//   fifo_count[2:0]  occupancy 0..4
//   fifo_full        occupancy == 4
//   overflow         sticky: a push was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module io_output (
  input  logic        io_clk,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  input  logic        write_io_enable,
  output logic [31:0] out_port0,
  output logic [31:0] out_port1,
  output logic [31:0] out_port2,
  output logic [31:0] stream_data,
  output logic        stream_valid,
  input  logic        stream_ready,
  output logic [2:0]  fifo_count,
  output logic        fifo_full,
  output logic        overflow
);

  localparam logic [5:0] ADDR_PORT0 = 6'b100000;  // 0x80
  localparam logic [5:0] ADDR_PORT1 = 6'b100001;  // 0x84
  localparam logic [5:0] ADDR_PORT2 = 6'b100010;  // 0x88
  localparam logic [5:0] ADDR_PUSH  = 6'b100011;  // 0x8C
  localparam logic [5:0] ADDR_CLEAR = 6'b100100;  // 0x90

  logic [31:0] fifo_mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;

  logic wr_port0, wr_port1, wr_port2, push_req, clear_req;
  logic pop, push_ok, drop;

  // NOTE: every signal driven in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_port0  = 1'b0;
    wr_port1  = 1'b0;
    wr_port2  = 1'b0;
    push_req  = 1'b0;
    clear_req = 1'b0;
    if (write_io_enable) begin
      unique case (addr[7:2])
        ADDR_PORT0: wr_port0  = 1'b1;
        ADDR_PORT1: wr_port1  = 1'b1;
        ADDR_PORT2: wr_port2  = 1'b1;
        ADDR_PUSH:  push_req  = 1'b1;
        ADDR_CLEAR: clear_req = 1'b1;
        default:    ;
      endcase
    end
  end

  assign stream_valid = (fifo_count != 3'd0);
  assign fifo_full    = (fifo_count == 3'd4);
  assign stream_data  = stream_valid ? fifo_mem[rd_ptr] : 32'h0;

  // A pop on the same edge frees a slot, so a push into a full FIFO is only
  // dropped when nothing leaves.
  assign pop     = stream_valid & stream_ready;
  assign push_ok = push_req & (~fifo_full | pop);
  assign drop    = push_req & fifo_full & ~pop;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      out_port0 <= 32'h0;
      out_port1 <= 32'h0;
      out_port2 <= 32'h0;
    end else begin
      if (wr_port0) out_port0 <= datain;
      if (wr_port1) out_port1 <= datain;
      if (wr_port2) out_port2 <= datain;
    end
  end

  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      fifo_count <= 3'd0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 2'd1;
      if (pop)     rd_ptr <= rd_ptr + 2'd1;
      fifo_count <= fifo_count + {2'b00, push_ok} - {2'b00, pop};
      // A drop wins over a clear on the same edge.
      overflow   <= (overflow & ~clear_req) | drop;
    end
  end

  // NOTE: the storage array has no reset; its contents are unobservable while
  // the pointers say empty, and leaving it out keeps it plain RAM.
  always_ff @(posedge io_clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= datain;
  end

endmodule

// File: doc/io_output.md
IO_OUTPUT -- requirements
Module: io_output

Interface
REQ-001 SHALL have port io_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port addr, input, 32 bits: store address; only addr[7:2] is decoded, addr[31:8] and addr[1:0] are ignored.
REQ-004 SHALL have port datain, input, 32 bits: store data.
REQ-005 SHALL have port write_io_enable, input, 1 bit: store strobe, sampled on the io_clk rising edge.
REQ-006 SHALL have ports out_port0, out_port1, out_port2, output, 32 bits each: registered output ports.
REQ-007 SHALL have port stream_data, output, 32 bits: FIFO head word.
REQ-008 SHALL have port stream_valid, output, 1 bit: FIFO non-empty.
REQ-009 SHALL have port stream_ready, input, 1 bit: consumer accepts the head word.
REQ-010 SHALL have port fifo_count, output, 3 bits: occupancy, 0..4.
REQ-011 SHALL have port fifo_full, output, 1 bit: fifo_count == 4.
REQ-012 SHALL have port overflow, output, 1 bit: sticky dropped-write flag.

Function
REQ-013 SHALL decode these addr[7:2] values when write_io_enable=1:
- 6'b100000 (0x80): out_port0 <= datain
- 6'b100001 (0x84): out_port1 <= datain
- 6'b100010 (0x88): out_port2 <= datain
- 6'b100011 (0x8C): push datain to the stream FIFO
- 6'b100100 (0x90): clear overflow; datain ignored
REQ-014 SHALL ignore writes to any other addr[7:2] value, and any cycle with write_io_enable=0; no state changes.
REQ-015 SHALL update out_port0..2 one edge after the store; each port holds its value until the next store to its address.
REQ-016 SHALL implement the stream FIFO as 4 entries of 32 bits, with 2-bit read and write pointers that wrap 3->0.
REQ-017 SHALL use first-word-fall-through: stream_valid = (fifo_count != 0); stream_data = the head entry when valid, else 32'h0.
REQ-018 SHALL assert stream_valid on the first edge after a push into an empty FIFO (1-cycle latency).
REQ-019 SHALL pop the head on an edge where stream_valid=1 and stream_ready=1; stream_ready while empty has no effect.
REQ-020 SHALL drop a push to 0x8C when fifo_full=1 and no pop occurs on the same edge; the drop sets overflow.
REQ-021 SHALL accept a push and a pop on the same edge when full: count stays 4, and the new word enters at the tail.
REQ-022 SHALL leave fifo_count unchanged on a simultaneous push and pop when not full or empty; on an empty FIFO, the push alone takes effect.
REQ-023 SHALL keep overflow set until a write to 0x90; if a drop and a clear occur on the same edge, overflow ends set.
REQ-024 SHALL hold stream_data stable while stream_valid=1 and stream_ready=0.

Reset
REQ-025 SHALL, while resetn=0, immediately force the following, independent of io_clk:
- out_port0..2 = 0
- both FIFO pointers = 0, fifo_count = 0, fifo_full = 0
- stream_valid = 0, stream_data = 0
- overflow = 0
REQ-026 SHALL leave FIFO storage contents uninitialised; they are unobservable while empty.
REQ-027 SHALL, if reset asserts mid-operation, discard all queued words; the first push after release lands at entry 0.
REQ-028 SHALL not act on a write presented in the same cycle resetn deasserts unless a rising edge occurs with resetn=1.

Verification
REQ-029 SHALL cover port writes: store 0x12345678 @0x80, 0xA5A5A5A5 @0x84, 0xFFFFFFFF @0x88 -> ports show those values one edge later; store @0x9C -> no change.
REQ-030 SHALL cover alias decode: store 0xDEAD0001 to addr 0xFFFFFF80 -> out_port0 = 0xDEAD0001.
REQ-031 SHALL cover FIFO fill and drain with stream_ready=0: push 1,2,3,4 -> fifo_count 4, fifo_full=1, stream_data=1; push 5 -> dropped, overflow=1; then stream_ready=1 -> 1,2,3,4 pop on consecutive edges, then stream_valid=0.
REQ-032 SHALL cover simultaneous push and pop when full: FIFO holds 1..4, push 9 with stream_ready=1 -> count stays 4, overflow stays 0, drain order 2,3,4,9.
REQ-033 SHALL cover overflow clear: overflow=1, write 0x90 -> overflow=0; full-FIFO push and 0x90 write on the same edge -> overflow=1.
REQ-034 SHALL cover mid-operation reset: FIFO holds 2 words, out_port1=0x55 -> pulse resetn low between edges -> all outputs 0 at once; next push 0x77 -> stream_data=0x77 one edge later.
